// File: rtl/fir_out_decim.sv
// fir_out_decim
// Output stage behind the 16-tap symmetric FIR. It keeps one of every DECIM
// valid input samples. Each kept sample is right-shifted by SHIFT, with
// optional round-half-up, and saturated to OUT_W bits. The result is then
// buffered in a small first-word-fall-through FIFO that a slower consumer
// drains through a valid/ready handshake.
//
// Build option:
//   FIR_DEC_ROUND_EN  defined   -> add 1<<(SHIFT-1) before the shift (round half up)
//                     undefined -> plain truncation
//   Latency and interface are the same in both builds.
//
// Ports:
//   clk         sample clock
//   rstn        asynchronous reset, active low
//   clr         synchronous clear of pipeline, decimation counter, FIFO and ovf
//   din_valid   input sample strobe (at most one sample per cycle)
//   din         unsigned filtered sample, IN_W bits
//   m_valid     FIFO not empty; m_data is meaningful
//   m_ready     consumer accepts m_data when m_valid && m_ready
//   m_data      FIFO head, OUT_W bits (0 while empty)
//   sat_pulse   one-cycle pulse when a kept sample saturated
//   ovf         sticky flag: a kept sample was dropped because the FIFO was full
//   fifo_level  FIFO occupancy, 0..2**FIFO_AW
module fir_out_decim #(
  parameter int IN_W    = 29,
  parameter int OUT_W   = 12,
  parameter int SHIFT   = 11,
  parameter int DECIM   = 4,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               din_valid,
  input  logic [IN_W-1:0]    din,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               sat_pulse,
  output logic               ovf,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int DCNT_W = 8;
  localparam int T_W    = IN_W + 1;
  localparam int Q_W    = T_W - SHIFT;

`ifdef FIR_DEC_ROUND_EN
  localparam logic [T_W-1:0] RND = T_W'(1) << (SHIFT - 1);
`else
  localparam logic [T_W-1:0] RND = '0;
`endif

  localparam logic [OUT_W-1:0]  OUT_MAX   = '1;
  localparam logic [Q_W-1:0]    Q_MAX     = Q_W'(OUT_MAX);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
  localparam logic [FIFO_AW:0]  FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

  logic [DCNT_W-1:0]  dcnt;
  logic               keep;

  logic               s1_valid;
  logic [T_W-1:0]     s1_t;
  logic [Q_W-1:0]     s1_q;
  logic               s1_sat;

  logic               s2_valid;
  logic [OUT_W-1:0]   s2_q;

  logic [OUT_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;

  // A sample is kept only when the decimation phase is zero. A sample that
  // arrives in a clr cycle is ignored.
  assign keep = din_valid && (dcnt == '0) && !clr;

  // The sample counter advances only on valid input cycles, so gaps in
  // din_valid do not shift the decimation phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt <= '0;
    end else if (clr) begin
      dcnt <= '0;
    end else if (din_valid) begin
      dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + 1'b1;
    end
  end

  // Stage 1: add the rounding constant. One extra bit of width means the
  // addition can never wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_t <= {1'b0, din} + RND;
      end
    end
  end

  assign s1_q   = Q_W'(s1_t >> SHIFT);
  assign s1_sat = s1_q > Q_MAX;

  // Stage 2: saturate the shifted value. The saturation pulse is registered
  // here, so it only ever belongs to a kept sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid  <= 1'b0;
      s2_q      <= '0;
      sat_pulse <= 1'b0;
    end else if (clr) begin
      s2_valid  <= 1'b0;
      s2_q      <= '0;
      sat_pulse <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      sat_pulse <= s1_valid && s1_sat;
      if (s1_valid) begin
        s2_q <= s1_sat ? OUT_MAX : s1_q[OUT_W-1:0];
      end
    end
  end

  // A push into a full FIFO is allowed when the consumer pops in the same
  // cycle. Without a pop, the sample is dropped and recorded in ovf.
  assign m_valid = (fifo_level != '0);
  assign full    = (fifo_level == FULL_LVL);
  assign pop     = m_valid && m_ready;
  assign push_ok = s2_valid && (!full || pop);
  assign drop    = s2_valid && full && !pop;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // FIFO storage and pointers. The pointers wrap naturally, and the level
  // register tells full apart from empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= s2_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
